// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file: round-robin grant among NREQ writeback units,
// registered wn/d/we output stage with $0 suppression and flush. Build option:
// REGFILE_WB_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module regfile_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req,
  input  logic [5*NREQ-1:0]  req_wn,
  input  logic [32*NREQ-1:0] req_d,
  input  logic               flush,
  output logic [NREQ-1:0]    gnt,
  output logic [4:0]         wn,
  output logic [31:0]        d,
  output logic               we,
  output logic               busy
);

  localparam int PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PtrW-1:0] ptr;
  logic [PtrW-1:0] sel_idx;
  logic [PtrW-1:0] scan_idx;
  logic            granted;
  logic [4:0]      sel_wn;
  logic [31:0]     sel_d;

  logic [4:0]      wn_q, wn_d;
  logic [31:0]     d_q, d_d;
  logic            we_q, we_d;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [PtrW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (granted) begin
      ptr_d = (sel_idx == PtrW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  // Scan ptr, ptr+1, ... modulo NREQ; first set request wins.
  always_comb begin
    gnt      = '0;
    granted  = 1'b0;
    sel_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PtrW'((int'(ptr) + k) % NREQ);
      if (!granted && req[scan_idx]) begin
        granted       = 1'b1;
        sel_idx       = scan_idx;
        gnt[scan_idx] = 1'b1;
      end
    end
    if (!clrn) begin
      gnt     = '0;
      granted = 1'b0;
    end
  end

  always_comb begin
    sel_wn = '0;
    sel_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_wn = req_wn[5*i +: 5];
        sel_d  = req_d[32*i +: 32];
      end
    end
  end

  // A $0 or flushed grant still completes; only the write enable is dropped.
  always_comb begin
    wn_d = wn_q;
    d_d  = d_q;
    we_d = 1'b0;
    if (granted) begin
      wn_d = sel_wn;
      d_d  = sel_d;
      we_d = (sel_wn != 5'd0) && !flush;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wn_q <= '0;
      d_q  <= '0;
      we_q <= 1'b0;
    end else begin
      wn_q <= wn_d;
      d_q  <= d_d;
      we_q <= we_d;
    end
  end

  assign wn   = wn_q;
  assign d    = d_q;
  assign we   = we_q;
  assign busy = clrn && |(req & ~gnt);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors, a behavioural arbitration model checked every
// cycle, and literal expectations from the block's documented scenarios.
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          clrn;
  logic [N-1:0]  req;
  logic [5*N-1:0]  req_wn;
  logic [32*N-1:0] req_d;
  logic          flush;
  logic [N-1:0]  gnt;
  logic [4:0]    wn;
  logic [31:0]   d;
  logic          we;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.NREQ(N)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .req    (req),
    .req_wn (req_wn),
    .req_d  (req_d),
    .flush  (flush),
    .gnt    (gnt),
    .wn     (wn),
    .d      (d),
    .we     (we),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] w, input logic [31:0] v);
    req_wn[5*i +: 5]  = w;
    req_d[32*i +: 32] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_wn;
  logic [31:0] m_d;

  function automatic int winner(input logic [N-1:0] r, input int p);
    int start;
    start = p;
`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    w = winner(req, m_ptr);
    if (!clrn) begin
      m_ptr = 0;
      m_we  = 1'b0;
      m_wn  = '0;
      m_d   = '0;
    end else if (w >= 0) begin
      m_wn  = req_wn[5*w +: 5];
      m_d   = req_d[32*w +: 32];
      m_we  = (req_wn[5*w +: 5] != 5'd0) && !flush;
      m_ptr = (w + 1) % N;
    end else begin
      m_we = 1'b0;
    end
  endtask

  initial begin : compare
    int w;
    logic [N-1:0] eg;
    @(posedge clk);
    model_edge();
    forever begin
      @(negedge clk);
      w  = winner(req, m_ptr);
      eg = '0;
      if (clrn && w >= 0) eg[w] = 1'b1;
      check("model_gnt", 32'(gnt), 32'(eg));
      check("model_busy", 32'(busy), 32'(clrn && |(req & ~eg)));
      check("model_we", 32'(we), 32'(m_we));
      check("model_wn", 32'(wn), 32'(m_wn));
      check("model_d", d, m_d);
      @(posedge clk);
      model_edge();
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : stim
    logic [N-1:0] rr_seq [6];
    logic [4:0]   rr_wn  [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_wn  = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};

    clrn  = 1'b0;
    flush = 1'b0;
    req   = 3'b111;
    set_src(0, 5'd1, 32'hA0A0_0000);
    set_src(1, 5'd2, 32'hB1B1_1111);
    set_src(2, 5'd3, 32'hC2C2_2222);
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_wn", 32'(wn), 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clrn = 1'b1;

`ifdef REGFILE_WB_ARB_FIXED_PRIO_EN
    req = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("fp_gnt", 32'(gnt), 32'b001);
      check("fp_busy", 32'(busy), 32'd1);
      step();
    end
    check("fp_we", 32'(we), 32'd1);
    check("fp_wn", 32'(wn), 32'd1);
`else
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_gnt", 32'(gnt), 32'(rr_seq[c]));
      if (c > 0) begin
        check("rr_we", 32'(we), 32'd1);
        check("rr_wn", 32'(wn), 32'(rr_wn[c-1]));
      end
      step();
    end
    check("rr_last_wn", 32'(wn), 32'd3);
    check("rr_last_d", d, 32'hC2C2_2222);

    // write to $0
    req = 3'b010;
    set_src(1, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("z_gnt", 32'(gnt), 32'b010);
    step();
    req = 3'b000;
    #1;
    check("z_we", 32'(we), 32'd0);
    check("z_d", d, 32'hDEAD_BEEF);
    step();
    req = 3'b111;
    #1;
    check("z_next", 32'(gnt), 32'b100);
    step();

    // flush drops the write, then the same write without flush lands
    req   = 3'b100;
    flush = 1'b1;
    set_src(2, 5'd7, 32'h1234_5678);
    #1;
    check("fl_gnt", 32'(gnt), 32'b100);
    step();
    req   = 3'b000;
    flush = 1'b0;
    #1;
    check("fl_we", 32'(we), 32'd0);
    step();
    req = 3'b100;
    #1;
    check("nf_gnt", 32'(gnt), 32'b100);
    step();
    req = 3'b000;
    #1;
    check("nf_we", 32'(we), 32'd1);
    check("nf_wn", 32'(wn), 32'd7);
    check("nf_d", d, 32'h1234_5678);
    step();

    // reset in mid-handshake
    set_src(1, 5'd2, 32'hB1B1_1111);
    req = 3'b110;
    #1;
    check("mr_gnt", 32'(gnt), 32'b010);
    step();
    clrn = 1'b0;
    #1;
    check("mr_gnt_rst", 32'(gnt), 32'd0);
    check("mr_busy_rst", 32'(busy), 32'd0);
    step();
    check("mr_we", 32'(we), 32'd0);
    clrn = 1'b1;
    #1;
    check("mr_gnt_rel", 32'(gnt), 32'b010);
    step();
`endif

    // a few mixed patterns checked by the model only
    req = 3'b101;
    step();
    step();
    req = 3'b011;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    req = 3'b000;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
